// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- shares one UART transmit channel among NREQ byte-stream
// requesters. The channel is granted per message (round-robin), so frames
// from different requesters never interleave. A holder that stops supplying
// bytes mid-message is evicted by a watchdog.
//
// Optional build macro: UART_ARB_TAG_EN -- prefix every message with one tag
// byte 8'hA0 | grant_id. When undefined the tag state is not built.
//
// Ports:
//   mclk, reset       clock (rising edge), asynchronous active-high reset
//   req_valid/data/last  per-requester byte stream (byte i at req_data[8i+:8])
//   req_ready         byte accepted; only the holder's bit can be 1
//   tx_valid/data     byte offered to the UART core, tx_ready accepts it
//   grant_id          current holder (held after release)
//   busy              arbiter is not idle
//   abort             one-cycle pulse on watchdog eviction
//   msg_cnt           completed messages, wraps
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [3:0]        grant_id,
    output logic              busy,
    output logic              abort,
    output logic [15:0]       msg_cnt
);

    localparam int          GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef UART_ARB_TAG_EN
        TAG  = 2'd1,
`endif
        XFER = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   hold;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic            any_req;
    logic [SW-1:0]   stall_cnt;
    logic [SW-1:0]   stall_inc;
    logic            wd_fire;
    logic            done;
    logic            evict;

    assign busy     = (state != IDLE);
    assign grant_id = 4'(hold);

    // Round-robin search starting just above the previous holder; the last
    // candidate examined is the previous holder itself.
    always_comb begin
        int unsigned idx;
        logic [GW-1:0] cand;
        idx     = 0;
        cand    = '0;
        pick    = '0;
        any_req = 1'b0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx  = (32'(last_grant) + i) % NR;
            cand = GW'(idx);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // Eviction happens on the edge where the stall count would reach TIMEOUT,
    // so abort and IDLE are both visible in the following cycle.
    assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    assign wd_fire   = (TIMEOUT != 0) && !req_valid[hold] &&
                       (32'(stall_inc) == TIMEOUT);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        done      = 1'b0;
        evict     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
`ifdef UART_ARB_TAG_EN
                    state_nxt = TAG;
`else
                    state_nxt = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 | {4'h0, grant_id};
                if (tx_ready) state_nxt = XFER;
            end
`endif
            XFER: begin
                tx_valid        = req_valid[hold];
                tx_data         = req_data[{hold, 3'b000} +: 8];
                req_ready[hold] = tx_ready;
                // A last-byte handshake wins over a simultaneous watchdog.
                if (tx_valid && tx_ready && req_last[hold]) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_fire) begin
                    evict     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            last_grant <= GW'(NREQ - 1);
            stall_cnt  <= '0;
            abort      <= 1'b0;
            msg_cnt    <= '0;
        end else begin
            state <= state_nxt;
            abort <= evict;
            if (state == IDLE && any_req) hold <= pick;
            if (done || evict) last_grant <= hold;
            if (done) msg_cnt <= msg_cnt + 16'd1;
            // Held at zero outside XFER, which also covers the entry clear.
            if (state != XFER || (tx_valid && tx_ready))
                stall_cnt <= '0;
            else if (!req_valid[hold])
                stall_cnt <= stall_inc;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (NREQ=4, TIMEOUT=8). Works with and
// without UART_ARB_TAG_EN.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef UART_ARB_TAG_EN
    localparam int TAGC = 1;
`else
    localparam int TAGC = 0;
`endif

    logic           mclk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [3:0]     grant_id;
    logic           busy;
    logic           abort;
    logic [15:0]    msg_cnt;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    uart_tx_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort),
        .msg_cnt   (msg_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, sample 2ns later.
    task automatic cyc(input logic [N-1:0] v, input logic [8*N-1:0] d,
                       input logic [N-1:0] l, input logic tr);
        @(negedge mclk);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = tr;
        #2;
    endtask

    task automatic do_reset();
        @(negedge mclk);
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        #2;
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst abort",     32'(abort),     32'd0);
        chk("rst msg_cnt",   32'(msg_cnt),   32'd0);
        chk("rst grant_id",  32'(grant_id),  32'd0);
        chk("rst tx_valid",  32'(tx_valid),  32'd0);
        chk("rst tx_data",   32'(tx_data),   32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        @(negedge mclk);
        reset = 1'b0;
    endtask

    // ---------------- table vectors (requester 0 only) ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       tr;
        logic       etv;
        logic [7:0] etd;
        logic       err;
        logic       ebusy;
        logic [15:0] ecnt;
    } vec_t;
    vec_t tbl[14];

    // ---------------- message-level reference model ----------------
    logic [7:0] mbytes[N][8];
    int         mlen[N];
    int         mk[N];
    logic       vld[N];
    int         idle[N];
    int         mh, mlast, mcnt;
    bit         mtag;
    int         fixed_len, pct_v, pct_tr;
    int         starts[$];

    task automatic new_msg(input int i);
        mlen[i] = (fixed_len != 0) ? fixed_len : 1 + int'($urandom_range(3));
        for (int j = 0; j < 8; j++) mbytes[i][j] = 8'($urandom);
        mk[i] = 0;
    endtask

    task automatic model_init();
        mh    = -1;
        mlast = N - 1;
        mcnt  = 0;
        mtag  = 1'b0;
        for (int i = 0; i < N; i++) begin
            vld[i]  = 1'b0;
            idle[i] = 0;
            new_msg(i);
        end
    endtask

    task automatic run(input int n);
        logic       prev_busy;
        logic       etv;
        logic [7:0] etd;
        logic [N-1:0] err;
        prev_busy = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge mclk);
            for (int i = 0; i < N; i++) begin
                if (!vld[i]) begin
                    // forced re-raise keeps every stall well under TIMEOUT
                    if (idle[i] >= 3 || int'($urandom_range(99)) < pct_v) begin
                        vld[i]  = 1'b1;
                        idle[i] = 0;
                    end else begin
                        idle[i]++;
                    end
                end
                req_valid[i]        = vld[i];
                req_data[8*i +: 8]  = mbytes[i][mk[i]];
                req_last[i]         = (mk[i] == mlen[i] - 1);
            end
            tx_ready = (int'($urandom_range(99)) < pct_tr);
            #2;
            etd = '0;
            err = '0;
            if (mh < 0) begin
                etv = 1'b0;
            end else if (mtag) begin
                etv = 1'b1;
                etd = 8'hA0 | 8'(mh);
            end else begin
                etv     = vld[mh];
                etd     = mbytes[mh][mk[mh]];
                err[mh] = tx_ready;
            end
            chk("rnd busy",      32'(busy),      32'(mh >= 0));
            chk("rnd tx_valid",  32'(tx_valid),  32'(etv));
            if (etv) chk("rnd tx_data", 32'(tx_data), 32'(etd));
            chk("rnd req_ready", 32'(req_ready), 32'(err));
            if (mh >= 0) chk("rnd grant_id", 32'(grant_id), 32'(mh));
            chk("rnd msg_cnt",   32'(msg_cnt),   32'(mcnt[15:0]));
            chk("rnd abort",     32'(abort),     32'd0);
            if (busy && !prev_busy) starts.push_back(int'(grant_id));
            prev_busy = busy;
            if (mh < 0) begin
                for (int j = 1; j <= N; j++)
                    if (mh < 0 && vld[(mlast + j) % N]) mh = (mlast + j) % N;
                mtag = (TAGC == 1) && (mh >= 0);
            end else if (mtag) begin
                if (tx_ready) mtag = 1'b0;
            end else if (vld[mh] && tx_ready && mk[mh] == mlen[mh] - 1) begin
                mcnt++;
                mlast = mh;
                mh    = -1;
            end
            for (int i = 0; i < N; i++) begin
                if (vld[i] && req_ready[i]) begin
                    vld[i] = 1'b0;
                    if (mk[i] == mlen[i] - 1) new_msg(i);
                    else mk[i]++;
                end
            end
        end
    endtask

    initial begin
        int exp_order[5];
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        fixed_len = 0;
        pct_v     = 50;
        pct_tr    = 70;
        exp_order = '{0, 1, 2, 3, 0};

        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 16'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 16'd1};
        tbl[7]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 16'd1};
        tbl[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 16'd1};
        tbl[9]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 16'd1};
        tbl[10] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 16'd1};
        tbl[11] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 16'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2};

        do_reset();
`ifndef UART_ARB_TAG_EN
        // single requester, then a backpressured 4-byte message
        for (int k = 0; k < 14; k++) begin
            cyc({3'b000, tbl[k].v}, {24'h0, tbl[k].d}, {3'b000, tbl[k].l}, tbl[k].tr);
            chk($sformatf("vec%0d tx_valid", k),  32'(tx_valid),     32'(tbl[k].etv));
            chk($sformatf("vec%0d tx_data", k),   32'(tx_data),      32'(tbl[k].etd));
            chk($sformatf("vec%0d req_ready", k), 32'(req_ready),    32'({3'b000, tbl[k].err}));
            chk($sformatf("vec%0d busy", k),      32'(busy),         32'(tbl[k].ebusy));
            chk($sformatf("vec%0d msg_cnt", k),   32'(msg_cnt),      32'(tbl[k].ecnt));
        end
`else
        // tag byte precedes payload
        cyc(4'b0010, {16'h0, 8'h55, 8'h00}, 4'b0010, 1'b1);
        chk("tag idle busy", 32'(busy), 32'd0);
        cyc(4'b0010, {16'h0, 8'h55, 8'h00}, 4'b0010, 1'b1);
        chk("tag tx_valid",  32'(tx_valid),  32'd1);
        chk("tag tx_data",   32'(tx_data),   32'hA1);
        chk("tag req_ready", 32'(req_ready), 32'd0);
        cyc(4'b0010, {16'h0, 8'h55, 8'h00}, 4'b0010, 1'b1);
        chk("tag payload",   32'(tx_data),   32'h55);
        chk("tag pay ready", 32'(req_ready), 32'b0010);
        cyc(4'b0000, '0, 4'b0000, 1'b1);
        chk("tag end busy",  32'(busy),      32'd0);
        chk("tag msg_cnt",   32'(msg_cnt),   32'd1);
`endif

        // round-robin with all requesters continuously holding 2-byte messages
        do_reset();
        fixed_len = 2;
        pct_v     = 100;
        pct_tr    = 100;
        model_init();
        starts.delete();
        run(16 + 5 * TAGC);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr order %0d", k),
                (k < starts.size()) ? 32'(starts[k]) : 32'hF, 32'(exp_order[k]));

        // watchdog: req2 sends one non-last byte then stalls, req3 waits
        do_reset();
        cyc(4'b0100, {8'h00, 8'h5A, 16'h0}, 4'b0000, 1'b1);
        chk("wd idle busy", 32'(busy), 32'd0);
        for (int k = 0; k <= TAGC; k++)
            cyc(4'b0100, {8'h00, 8'h5A, 16'h0}, 4'b0000, 1'b1);
        chk("wd byte data",  32'(tx_data),   32'h5A);
        chk("wd byte ready", 32'(req_ready), 32'b0100);
        chk("wd grant2",     32'(grant_id),  32'd2);
        for (int k = 0; k < TO; k++) begin
            cyc(4'b1000, {8'h77, 24'h0}, 4'b1000, 1'b1);
            chk($sformatf("wd stall%0d abort", k), 32'(abort), 32'd0);
            chk($sformatf("wd stall%0d busy", k),  32'(busy),  32'd1);
        end
        cyc(4'b1000, {8'h77, 24'h0}, 4'b1000, 1'b1);
        chk("wd abort",      32'(abort),   32'd1);
        chk("wd abort idle", 32'(busy),    32'd0);
        chk("wd msg_cnt",    32'(msg_cnt), 32'd0);
        cyc(4'b1000, {8'h77, 24'h0}, 4'b1000, 1'b1);
        chk("wd abort pulse", 32'(abort),    32'd0);
        chk("wd next grant",  32'(grant_id), 32'd3);
        chk("wd next busy",   32'(busy),     32'd1);

        // reset in the middle of a message
        do_reset();
        cyc(4'b0001, {24'h0, 8'hAA}, 4'b0000, 1'b1);
        for (int k = 0; k <= TAGC; k++)
            cyc(4'b0001, {24'h0, 8'hAA}, 4'b0000, 1'b1);
        cyc(4'b0001, {24'h0, 8'hBB}, 4'b0000, 1'b0);
        chk("mid tx_valid", 32'(tx_valid), 32'd1);
        chk("mid tx_data",  32'(tx_data),  32'hBB);
        reset     = 1'b1;
        req_valid = '0;
        #1;
        chk("async tx_valid",  32'(tx_valid),  32'd0);
        chk("async busy",      32'(busy),      32'd0);
        chk("async req_ready", 32'(req_ready), 32'd0);
        @(negedge mclk);
        reset = 1'b0;
        cyc(4'b0011, {16'h0, 8'hCC, 8'hDD}, 4'b0011, 1'b1);
        chk("post rst idle", 32'(busy), 32'd0);
        cyc(4'b0011, {16'h0, 8'hCC, 8'hDD}, 4'b0011, 1'b1);
        chk("post rst grant", 32'(grant_id), 32'd0);
        chk("post rst busy",  32'(busy),     32'd1);

        // randomized traffic against the model
        do_reset();
        fixed_len = 0;
        pct_v     = 50;
        pct_tr    = 70;
        model_init();
        run(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and message sequencer that shares one UART transmit channel among NREQ byte-stream requesters. It grants the channel per message, not per byte, so frames from different requesters never interleave. A stalled holder is evicted by a watchdog. It sits between the on-chip byte producers and the UART core's transmit-holding/FIFO interface.

## Interface
- NREQ, 4: number of requesters, 2..16
- TIMEOUT, 1024: idle cycles allowed mid-message before eviction; 0 disables the watchdog
- mclk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a byte on req_data[8*i+7:8*i]
- req_data  in  8*NREQ  packed request bytes
- req_last  in  NREQ  the byte is the last of its message
- req_ready  out  NREQ  byte accepted; only the granted bit can be 1
- tx_valid  out  1  byte offered to the UART core
- tx_data  out  8  byte to the UART core
- tx_ready  in  1  UART core accepts the byte this cycle
- grant_id  out  4  index of the current holder; held after release
- busy  out  1  state is not IDLE
- abort  out  1  one-cycle pulse on watchdog eviction
- msg_cnt  out  16  count of completed messages; wraps

## Operation
- States: IDLE, TAG (only with UART_ARB_TAG_EN), XFER.
- Handshake: a byte transfers in a cycle where tx_valid and tx_ready are both 1. A requester must hold req_valid, data and last until req_ready.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_grant+1 upward, with modulo-NREQ wrap.
  - Register grant_id and go to TAG or XFER.
  - Outputs: tx_valid=0, req_ready=0.
- TAG:
  - tx_valid=1, tx_data = 8'hA0 | grant_id.
  - On tx_ready, go to XFER. req_ready stays 0.
- XFER (combinational pass-through from the holder g):
  - tx_valid = req_valid[g], tx_data = req_data[g].
  - req_ready[g] = tx_ready. All other req_ready bits are 0.
- End of message: a handshake with req_last[g]=1:
  - Set last_grant=g, increment msg_cnt, go to IDLE.
- Watchdog:
  - stall_cnt clears on entry to XFER and on every handshake.
  - It increments in XFER cycles where req_valid[g]=0.
  - When stall_cnt reaches TIMEOUT (TIMEOUT≠0): pulse abort, set last_grant=g, go to IDLE. msg_cnt is not incremented.
  - stall_cnt is width-saturating and is not counted in TAG.
- Requests from non-holders are ignored until the holder releases. Their req_valid may toggle freely.
- Reset mid-message: everything returns to reset values at once. The partial message is dropped, and the UART core sees tx_valid fall asynchronously.

## Timing
- Reset values:
  - state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), grant_id=0
  - busy=0, abort=0, msg_cnt=0, stall_cnt=0
  - tx_valid=0, tx_data=0, req_ready=0
- Grant latency: req_valid rises in cycle N; grant_id and busy update at the edge ending N; the first tx_valid (tag or data) is in cycle N+1.
- Re-arbitration: after the last-byte handshake in cycle M, state is IDLE in M+1; the next holder's first byte appears at M+2. The minimum gap between messages is 1 idle cycle.
- Data path is combinational in XFER: there is no extra latency from req to tx and none from tx_ready to req_ready.
- abort asserts in the cycle after stall_cnt reaches TIMEOUT and lasts exactly 1 cycle. The state is IDLE in that same cycle.
- A last-byte handshake in the same cycle the watchdog would fire counts as completion: no abort, msg_cnt increments.

## Configuration
- UART_ARB_TAG_EN:
  - Defined: each message is preceded by one tag byte 8'hA0|grant_id through the TAG state, so grant-to-first-data latency becomes at least 2 cycles.
  - Undefined: the TAG state and its logic are not built; the IDLE→XFER transition is direct and the stream contains payload bytes only.

## Test plan
- Single requester: req0 sends 3 bytes 8'h11, 8'h22, 8'h33(last), tx_ready=1 → tx sees 11, 22, 33 on consecutive cycles starting 1 cycle after request; msg_cnt=1; busy falls.
- Round-robin: req0..3 all hold 2-byte messages continuously → grant order 0,1,2,3,0, with no byte interleaving and a 1-cycle IDLE between messages.
- Backpressure: tx_ready toggles 1,0,1,0 during a 4-byte message → each byte is held stable until accepted; req_ready mirrors tx_ready; no bytes lost.
- Watchdog: TIMEOUT=8; req2 sends 1 non-last byte, then drops req_valid → abort pulses 9 cycles later; grant moves to the next pending requester (3); msg_cnt unchanged.
- Reset mid-message: assert reset during byte 2 of a 4-byte message → tx_valid=0 and busy=0 immediately; after release, requester 0 wins first.
- Tag (UART_ARB_TAG_EN defined): req1 sends 8'h55(last) → tx stream is A1 then 55.
